// File: rtl/tinyriscv_pkg.sv
// Shared types for the APB arbiter and related bus logic.
//   apb_state_e  : APB transfer phase (IDLE / SETUP / ACCESS)
//   ApbProtWidth : width of the APB4 pprot field
package tinyriscv_pkg;

  localparam int unsigned ApbProtWidth = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/rr_arb.sv
// Round-robin priority picker: the first requester above i_last (with wrap) wins.
//   i_req  : request vector, one bit per requester
//   i_last : index of the most recently served requester
//   o_gnt  : one-hot grant (all zero when nobody requests)
//   o_idx  : index of the granted requester (0 when nobody requests)
module rr_arb #(
  parameter  int unsigned N    = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_last,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_idx
);

  logic        w_found;
  int unsigned w_cand;

  // Scan from last+1 upward with wrap; last itself is checked last.
  always_comb begin
    w_found = 1'b0;
    w_cand  = 0;
    o_idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = (32'(i_last) + k) % N;
      if (!w_found && i_req[IdxW'(w_cand)]) begin
        w_found = 1'b1;
        o_idx   = IdxW'(w_cand);
      end
    end
    o_gnt = w_found ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/apb_arbiter.sv
// Shares one APB4 slave bus between NumMst APB4 masters, round-robin,
// one transfer at a time with the grant held for the whole transfer.
//   clk_i, rst_ni             : clock, async active-low reset
//   m_psel_i .. m_pprot_i     : per-master APB4 request/payload
//   m_prdata_o                : read data broadcast, nonzero only on completion
//   m_pready_o, m_pslverr_o   : per-master completion/error, granted bit only
//   s_psel_o .. s_pprot_o     : shared slave-side request/payload
//   s_prdata_i, s_pready_i,
//   s_pslverr_i               : slave response
module apb_arbiter
  import tinyriscv_pkg::*;
#(
  parameter int unsigned NumMst    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NumMst-1:0]                         m_psel_i,
  input  logic [NumMst-1:0]                         m_penable_i,
  input  logic [NumMst-1:0]                         m_pwrite_i,
  input  logic [NumMst-1:0][AddrWidth-1:0]          m_paddr_i,
  input  logic [NumMst-1:0][DataWidth-1:0]          m_pwdata_i,
  input  logic [NumMst-1:0][DataWidth/8-1:0]        m_pstrb_i,
  input  logic [NumMst-1:0][ApbProtWidth-1:0]       m_pprot_i,
  output logic [DataWidth-1:0]                      m_prdata_o,
  output logic [NumMst-1:0]                         m_pready_o,
  output logic [NumMst-1:0]                         m_pslverr_o,
  output logic                                      s_psel_o,
  output logic                                      s_penable_o,
  output logic                                      s_pwrite_o,
  output logic [AddrWidth-1:0]                      s_paddr_o,
  output logic [DataWidth-1:0]                      s_pwdata_o,
  output logic [DataWidth/8-1:0]                    s_pstrb_o,
  output logic [ApbProtWidth-1:0]                   s_pprot_o,
  input  logic [DataWidth-1:0]                      s_prdata_i,
  input  logic                                      s_pready_i,
  input  logic                                      s_pslverr_i
);

  localparam int unsigned IdxW = (NumMst > 1) ? $clog2(NumMst) : 1;

  apb_state_e        r_state;
  apb_state_e        w_state_nxt;
  logic [IdxW-1:0]   r_gnt;
  logic [IdxW-1:0]   r_last;
  logic [IdxW-1:0]   w_rr_idx;
  logic [NumMst-1:0] w_rr_gnt;
  logic [NumMst-1:0] w_gnt_oh;
  logic              w_gnt_load;
  logic              w_last_load;
  logic              w_done;
  logic              w_unused;

  // penable is implied by the arbiter's own phase tracking; the one-hot grant is spare.
  assign w_unused = ^{m_penable_i, w_rr_gnt};

  rr_arb #(.N(NumMst)) u_rr_arb (
    .i_req  (m_psel_i),
    .i_last (r_last),
    .o_gnt  (w_rr_gnt),
    .o_idx  (w_rr_idx)
  );

  // State, grant and round-robin history registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_last  <= IdxW'(NumMst - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_load)  r_gnt  <= w_rr_idx;
      if (w_last_load) r_last <= r_gnt;
    end
  end

  // Next-state and slave phase control.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_load  = 1'b0;
    w_last_load = 1'b0;
    w_done      = 1'b0;
    s_psel_o    = 1'b0;
    s_penable_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (|m_psel_i) begin
          w_gnt_load  = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        s_psel_o    = 1'b1;
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        s_psel_o    = 1'b1;
        s_penable_o = 1'b1;
        if (s_pready_i) begin
          w_done      = 1'b1;
          w_last_load = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_gnt_oh = NumMst'(1) << r_gnt;

  // Payload mux from the granted master (masters hold it stable while selected)
  // and completion routing back to that master only.
  always_comb begin
    s_pwrite_o  = 1'b0;
    s_paddr_o   = '0;
    s_pwdata_o  = '0;
    s_pstrb_o   = '0;
    s_pprot_o   = '0;
    m_prdata_o  = '0;
    m_pready_o  = '0;
    m_pslverr_o = '0;
    if (r_state != IDLE) begin
      s_pwrite_o = m_pwrite_i[r_gnt];
      s_paddr_o  = m_paddr_i[r_gnt];
      s_pwdata_o = m_pwdata_i[r_gnt];
      s_pstrb_o  = m_pstrb_i[r_gnt];
      s_pprot_o  = m_pprot_i[r_gnt];
    end
    if (w_done) begin
      m_prdata_o  = s_prdata_i;
      m_pready_o  = w_gnt_oh;
      m_pslverr_o = s_pslverr_i ? w_gnt_oh : '0;
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
`timescale 1ns/1ps
module tb_apb_arbiter;
  import tinyriscv_pkg::*;

  localparam int unsigned NumMst = 2;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned SW     = DW / 8;

  typedef struct {
    int          mst;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          gap;
    int          withdraw;
  } item_t;

  logic                                clk_i;
  logic                                rst_ni;
  logic [NumMst-1:0]                   m_psel_i;
  logic [NumMst-1:0]                   m_penable_i;
  logic [NumMst-1:0]                   m_pwrite_i;
  logic [NumMst-1:0][AW-1:0]           m_paddr_i;
  logic [NumMst-1:0][DW-1:0]           m_pwdata_i;
  logic [NumMst-1:0][SW-1:0]           m_pstrb_i;
  logic [NumMst-1:0][ApbProtWidth-1:0] m_pprot_i;
  logic [DW-1:0]                       m_prdata_o;
  logic [NumMst-1:0]                   m_pready_o;
  logic [NumMst-1:0]                   m_pslverr_o;
  logic                                s_psel_o;
  logic                                s_penable_o;
  logic                                s_pwrite_o;
  logic [AW-1:0]                       s_paddr_o;
  logic [DW-1:0]                       s_pwdata_o;
  logic [SW-1:0]                       s_pstrb_o;
  logic [ApbProtWidth-1:0]             s_pprot_o;
  logic [DW-1:0]                       s_prdata_i;
  logic                                s_pready_i;
  logic                                s_pslverr_i;

  int    checks = 0;
  int    errors = 0;
  int    g_waits = 0;
  logic  g_err = 1'b0;
  bit    abort = 1'b0;
  item_t mq0[$];
  item_t mq1[$];
  item_t sb[$];

  apb_arbiter #(.NumMst(NumMst), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m_psel_i    (m_psel_i),
    .m_penable_i (m_penable_i),
    .m_pwrite_i  (m_pwrite_i),
    .m_paddr_i   (m_paddr_i),
    .m_pwdata_i  (m_pwdata_i),
    .m_pstrb_i   (m_pstrb_i),
    .m_pprot_i   (m_pprot_i),
    .m_prdata_o  (m_prdata_o),
    .m_pready_o  (m_pready_o),
    .m_pslverr_o (m_pslverr_o),
    .s_psel_o    (s_psel_o),
    .s_penable_o (s_penable_o),
    .s_pwrite_o  (s_pwrite_o),
    .s_paddr_o   (s_paddr_o),
    .s_pwdata_o  (s_pwdata_o),
    .s_pstrb_o   (s_pstrb_o),
    .s_pprot_o   (s_pprot_o),
    .s_prdata_i  (s_prdata_i),
    .s_pready_i  (s_pready_i),
    .s_pslverr_i (s_pslverr_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=completion", name);
  endtask

  function automatic item_t mk(input int mst, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                               input logic [31:0] rdata, input logic err, input int acc, input int gap,
                               input int withdraw);
    item_t it;
    it.mst = mst; it.wr = wr; it.addr = addr; it.wdata = wdata; it.strb = strb; it.prot = prot;
    it.rdata = rdata; it.err = err; it.acc = acc; it.gap = gap; it.withdraw = withdraw;
    return it;
  endfunction

  // Stimulus hand-off: master queue always, scoreboard only for transfers expected to complete.
  task automatic issue(input item_t it, input bit to_sb);
    if (it.mst == 0) mq0.push_back(it);
    else             mq1.push_back(it);
    if (to_sb) sb.push_back(it);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() > 0 || mq0.size() > 0 || mq1.size() > 0 || m_psel_i != '0) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= budget) begin
      fail_now("drain");
      sb.delete(); mq0.delete(); mq1.delete();
    end
    repeat (2) @(negedge clk_i);
  endtask

  // Master drivers: hold psel until own pready, optional withdraw, abort on reset.
  initial begin : drv
    item_t       cur [NumMst];
    bit          act [NumMst];
    bit          fr  [NumMst];
    int          wcnt[NumMst];
    logic [0:0]  k;
    m_psel_i = '0; m_penable_i = '0; m_pwrite_i = '0; m_paddr_i = '0;
    m_pwdata_i = '0; m_pstrb_i = '0; m_pprot_i = '0;
    for (int i = 0; i < NumMst; i++) begin act[i] = 1'b0; fr[i] = 1'b0; wcnt[i] = 0; end
    forever begin
      @(negedge clk_i);
      for (int i = 0; i < NumMst; i++) begin
        k = 1'(i);
        if (act[i]) begin
          if (abort) act[i] = 1'b0;
          else if (m_pready_o[k]) act[i] = 1'b0;
          else begin
            wcnt[i]++;
            if (cur[i].withdraw > 0 && wcnt[i] >= cur[i].withdraw) act[i] = 1'b0;
            else if (wcnt[i] > 40) begin
              fail_now("master_wait");
              act[i] = 1'b0;
            end
          end
        end
      end
      @(posedge clk_i);
      #1;
      for (int i = 0; i < NumMst; i++) begin
        k = 1'(i);
        if (!act[i] && !abort) begin
          if (i == 0 && mq0.size() > 0) begin
            cur[i] = mq0.pop_front(); act[i] = 1'b1; fr[i] = 1'b1; wcnt[i] = 0;
          end else if (i == 1 && mq1.size() > 0) begin
            cur[i] = mq1.pop_front(); act[i] = 1'b1; fr[i] = 1'b1; wcnt[i] = 0;
          end
        end
        m_psel_i[k]    = act[i];
        m_penable_i[k] = act[i] && !fr[i];
        fr[i]          = 1'b0;
        m_pwrite_i[k]  = act[i] ? cur[i].wr    : 1'b0;
        m_paddr_i[k]   = act[i] ? cur[i].addr  : '0;
        m_pwdata_i[k]  = act[i] ? cur[i].wdata : '0;
        m_pstrb_i[k]   = act[i] ? cur[i].strb  : '0;
        m_pprot_i[k]   = act[i] ? cur[i].prot  : '0;
      end
    end
  end

  // Slave model: g_waits wait states, read data = addr ^ 0xDEADBFEF, writes return 0.
  initial begin : slv
    int cnt;
    cnt = 0;
    s_pready_i = 1'b0; s_prdata_i = '0; s_pslverr_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (s_psel_o && s_penable_o) begin
        if (cnt == g_waits) begin
          s_pready_i  = 1'b1;
          s_prdata_i  = s_pwrite_o ? 32'h0 : (s_paddr_o ^ 32'hDEADBFEF);
          s_pslverr_i = g_err;
        end else begin
          s_pready_i = 1'b0; s_prdata_i = '0; s_pslverr_i = 1'b0;
        end
        cnt++;
      end else begin
        cnt = 0;
        s_pready_i = 1'b0; s_prdata_i = '0; s_pslverr_i = 1'b0;
      end
    end
  end

  // Monitor: pop the scoreboard on every completion and compare the whole transfer.
  initial begin : mon
    int          acc;
    int          cyc;
    int          last_done;
    bit          chk_idle;
    item_t       e;
    logic [1:0]  exp_mask;
    acc = 0; cyc = 0; last_done = 0; chk_idle = 1'b0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_ni) begin
        acc = 0;
        chk_idle = 1'b0;
      end else begin
        if (chk_idle) begin
          check("idle_after_done", s_psel_o, 0);
          chk_idle = 1'b0;
        end
        if (s_psel_o && s_penable_o) acc++;
        if (m_pready_o != '0) begin
          if (sb.size() == 0) begin
            check("unexpected_pready", m_pready_o, 0);
          end else begin
            e = sb.pop_front();
            exp_mask = (e.mst == 0) ? 2'b01 : 2'b10;
            check("pready_mask", m_pready_o, exp_mask);
            check("prdata", m_prdata_o, e.rdata);
            check("pslverr", m_pslverr_o, e.err ? exp_mask : 2'b00);
            check("s_paddr", s_paddr_o, e.addr);
            check("s_pwrite", s_pwrite_o, e.wr);
            check("s_pwdata", s_pwdata_o, e.wdata);
            check("s_pstrb", s_pstrb_o, e.strb);
            check("s_pprot", s_pprot_o, e.prot);
            check("access_cycles", acc, e.acc);
            if (e.gap > 0) check("done_spacing", cyc - last_done, e.gap);
          end
          last_done = cyc;
          acc = 0;
          chk_idle = 1'b1;
        end else begin
          check("prdata_quiet", m_prdata_o, 0);
          check("pslverr_quiet", m_pslverr_o, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin : main
    int n;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_s_psel", s_psel_o, 0);
    check("rst_s_penable", s_penable_o, 0);
    check("rst_s_paddr", s_paddr_o, 0);
    check("rst_m_pready", m_pready_o, 0);
    check("rst_m_prdata", m_prdata_o, 0);
    check("rst_m_pslverr", m_pslverr_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Both request after reset: master 0 first, then master 1.
    issue(mk(0, 1'b0, 32'h200, 32'h0, 4'hF, 3'b000, 32'hDEADBDEF, 1'b0, 1, 0, 0), 1'b1);
    issue(mk(1, 1'b0, 32'h300, 32'h0, 4'hF, 3'b001, 32'hDEADBCEF, 1'b0, 1, 0, 0), 1'b1);
    drain(100);

    // Continuous 4 writes each: 0,1,0,1,... three cycles apart.
    for (int i = 0; i < 4; i++) begin
      issue(mk(0, 1'b1, 32'h1000 + 32'(4 * i), 32'hA0000000 + 32'(i), 4'hF, 3'b010,
               32'h0, 1'b0, 1, (i == 0) ? 0 : 3, 0), 1'b1);
      issue(mk(1, 1'b1, 32'h2000 + 32'(4 * i), 32'hB0000000 + 32'(i), 4'b1100, 3'b001,
               32'h0, 1'b0, 1, 3, 0), 1'b1);
    end
    drain(200);

    // Minimum latency, single master 0 read.
    issue(mk(0, 1'b0, 32'h100, 32'h0, 4'hF, 3'b000, 32'hDEADBEEF, 1'b0, 1, 0, 0), 1'b1);
    @(negedge clk_i);
    check("lat_c0_psel", s_psel_o, 0);
    @(negedge clk_i);
    check("lat_c1_psel", s_psel_o, 1);
    check("lat_c1_penable", s_penable_o, 0);
    @(negedge clk_i);
    check("lat_c2_penable", s_penable_o, 1);
    check("lat_c2_pready", m_pready_o, 2'b01);
    check("lat_c2_prdata", m_prdata_o, 32'hDEADBEEF);
    @(negedge clk_i);
    check("lat_c3_psel", s_psel_o, 0);
    drain(100);

    // Wait states and slave error on master 1 write.
    g_waits = 3; g_err = 1'b1;
    issue(mk(1, 1'b1, 32'hE0000000, 32'hCAFEF00D, 4'b0011, 3'b100, 32'h0, 1'b1, 4, 0, 0), 1'b1);
    drain(100);
    g_err = 1'b0;

    // Master 1 withdraws while waiting; master 0 keeps getting served.
    issue(mk(0, 1'b0, 32'h400, 32'h0, 4'hF, 3'b000, 32'hDEADBBEF, 1'b0, 4, 0, 0), 1'b1);
    issue(mk(0, 1'b0, 32'h500, 32'h0, 4'hF, 3'b000, 32'hDEADBAEF, 1'b0, 4, 0, 0), 1'b1);
    @(negedge clk_i);
    issue(mk(1, 1'b0, 32'h600, 32'h0, 4'hF, 3'b000, 32'h0, 1'b0, 0, 0, 2), 1'b0);
    drain(200);

    // Reset during ACCESS; round-robin history returns to its reset value.
    issue(mk(0, 1'b0, 32'h700, 32'h0, 4'hF, 3'b000, 32'h0, 1'b0, 0, 0, 0), 1'b0);
    n = 0;
    while (!s_penable_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("reach_access", s_penable_o, 1);
    abort  = 1'b1;
    rst_ni = 1'b0;
    sb.delete();
    #1;
    check("async_rst_psel", s_psel_o, 0);
    check("async_rst_penable", s_penable_o, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    abort = 1'b0;
    g_waits = 0;
    @(negedge clk_i);
    check("post_rst_psel", s_psel_o, 0);
    issue(mk(0, 1'b0, 32'h800, 32'h0, 4'hF, 3'b000, 32'hDEADB7EF, 1'b0, 1, 0, 0), 1'b1);
    issue(mk(1, 1'b0, 32'h900, 32'h0, 4'hF, 3'b000, 32'hDEADB6EF, 1'b0, 1, 0, 0), 1'b1);
    drain(100);
    issue(mk(1, 1'b0, 32'hA00, 32'h0, 4'hF, 3'b011, 32'hDEADB5EF, 1'b0, 1, 0, 0), 1'b1);
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Shares the single APB4 peripheral bus between NumMst APB4 masters.
- Master 0 is the core's execute-stage data port; master 1 is the debug/JTAG memory-access path. Further indices are reserved for a future DMA.
- Each master sees a normal APB4 slave and is stalled through m_pready_o while another master owns the bus.
- Arbitration is round-robin, one transfer at a time; the grant is held for a whole transfer.

Parameters:
- NumMst, 2: number of requesting masters (≥2).
- AddrWidth, 32: APB address width.
- DataWidth, 32: APB data width; strobe width is DataWidth/8.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  reset; asynchronous assertion, active-low.
- m_psel_i  in  NumMst  per-master select (request).
- m_penable_i  in  NumMst  per-master enable.
- m_pwrite_i  in  NumMst  per-master write flag.
- m_paddr_i  in  NumMst x AddrWidth  per-master address.
- m_pwdata_i  in  NumMst x DataWidth  per-master write data.
- m_pstrb_i  in  NumMst x DataWidth/8  per-master byte strobes.
- m_pprot_i  in  NumMst x 3  per-master protection.
- m_prdata_o  out  DataWidth  read data, broadcast to all masters.
- m_pready_o  out  NumMst  per-master ready; only the granted bit can be high.
- m_pslverr_o  out  NumMst  per-master error; valid only with m_pready_o.
- s_psel_o  out  1  slave select.
- s_penable_o  out  1  slave enable.
- s_pwrite_o  out  1  slave write flag.
- s_paddr_o  out  AddrWidth  slave address.
- s_pwdata_o  out  DataWidth  slave write data.
- s_pstrb_o  out  DataWidth/8  slave byte strobes.
- s_pprot_o  out  3  slave protection.
- s_prdata_i  in  DataWidth  slave read data.
- s_pready_i  in  1  slave ready.
- s_pslverr_i  in  1  slave error.

Behaviour:
- Reset:
  - state=IDLE, gnt_q=0, last_q=NumMst-1.
  - All s_* outputs 0; m_pready_o=0, m_pslverr_o=0, m_prdata_o=0.
- FSM: IDLE, SETUP, ACCESS.
- IDLE:
  - If any m_psel_i is high, pick the winner with rr_arb and register it into gnt_q.
  - Go to SETUP next cycle.
  - s_psel_o=0 while in IDLE.
- SETUP: s_psel_o=1, s_penable_o=0; always go to ACCESS next cycle.
- ACCESS:
  - s_psel_o=1, s_penable_o=1.
  - When s_pready_i=1 (same cycle, combinational):
    - m_pready_o[gnt_q]=1.
    - m_pslverr_o[gnt_q]=s_pslverr_i.
    - m_prdata_o=s_prdata_i.
    - last_q<=gnt_q; go to IDLE.
  - When s_pready_i=0, stay in ACCESS.
- Slave payload (pwrite, paddr, pwdata, pstrb, pprot):
  - Combinational mux of master gnt_q in SETUP/ACCESS; 0 in IDLE.
  - Masters hold their payload stable while psel is high (APB4 rule), so no payload latching.
- Minimum latency: request seen at cycle 0 with the arbiter in IDLE → s_psel cycle 1 → s_penable cycle 2 → master pready at cycle 2 if the slave is zero-wait.
- There is always one IDLE cycle between consecutive slave transfers; no back-to-back transfers.
- Round-robin rule:
  - Winner is the first requester at index (last_q+1) mod NumMst, then upward with wrap-around.
  - A sole requester wins regardless of last_q.
  - last_q updates only on transfer completion.
- Non-granted masters: m_pready_o bit held 0. Their request may be withdrawn or changed freely with no effect.
- Granted master drops m_psel_i mid-transfer (protocol violation): the slave transfer still completes; the completion pulse is still driven on m_pready_o[gnt_q].
- Simultaneous request and completion: a new request seen in the completion cycle is evaluated in the following IDLE cycle.
- Reset mid-transfer: s_psel_o and s_penable_o drop asynchronously; the FSM returns to IDLE; the transfer is lost.
- m_prdata_o is 0 except in the completion cycle.

Decomposition:
- Shared package tinyriscv_pkg:
  - apb_state_e enum (IDLE/SETUP/ACCESS).
  - ApbProtWidth=3 constant.
- Sub-module rr_arb:
  - Parameter N.
  - Inputs req[N], last index.
  - Outputs one-hot gnt and index.
  - Combinational rotate-priority; reusable by the future DMA scheduler.

Test Plan:
- Single master 0 read, zero-wait slave returning 0xDEADBEEF → s_psel cycle 1, s_penable cycle 2, m_pready_o=2'b01 and m_prdata_o=0xDEADBEEF in cycle 2, IDLE in cycle 3.
- Both masters request at the same time after reset → master 0 served first; master 1 served next with s_paddr_o=m_paddr_i[1]; m_pready_o[1] stays 0 during master 0's transfer.
- Both masters continuously request 4 writes each → grants alternate 0,1,0,1,...; each transfer separated by exactly one IDLE cycle.
- Slave inserts 3 wait states and pslverr=1 on master 1's write → ACCESS held 4 cycles; m_pslverr_o=2'b10 only in the pready cycle.
- rst_ni asserted low during ACCESS → s_psel_o/s_penable_o = 0 immediately; after release, a master 1 request is granted with last_q=NumMst-1 preserved as reset value.
- Master 1 withdraws psel while waiting, master 0 requests → master 0 granted, master 1 never sees pready.
